// File: rtl/stopwatch_display_if.sv
`default_nettype none
// ------------------------------------------------------------------
// stopwatch_display_if : core-side inputs and display-side outputs
// Revision 1.0
// ------------------------------------------------------------------
interface stopwatch_display_if;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ovf;
  logic       upd;

  modport master (
    output minutes, seconds, status,
    input  an, seg, dp, ovf, upd
  );

  modport slave (
    input  minutes, seconds, status,
    output an, seg, dp, ovf, upd
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ------------------------------------------------------------------
// stopwatch_display : MM:SS BCD conversion and 4-digit 7-seg scanning
// Revision 1.0
// ------------------------------------------------------------------
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stopwatch_display_if.slave disp_if
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_DIV = 1'b1} state_t;

  state_t      state_q;
  logic [6:0]  snap_min_q, work_min_q;
  logic [5:0]  snap_sec_q, work_sec_q;
  logic [3:0]  tens_min_q, tens_sec_q;
  logic        ovf_pend_q, ovf_q, upd_q;
  logic [15:0] digits_q;

  logic [6:0]  min_clamp;
  logic [5:0]  sec_clamp;
  logic        min_over;

  always_comb begin
    min_over  = (disp_if.minutes > 8'd99);
    min_clamp = min_over ? 7'd99 : disp_if.minutes[6:0];
    sec_clamp = (disp_if.seconds > 6'd59) ? 6'd59 : disp_if.seconds;
  end

  // Iterative divide: one subtract-by-ten per edge on each working reg in parallel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      work_min_q <= '0;
      work_sec_q <= '0;
      tens_min_q <= '0;
      tens_sec_q <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      upd_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ({min_clamp, sec_clamp} != {snap_min_q, snap_sec_q}) begin
            snap_min_q <= min_clamp;
            snap_sec_q <= sec_clamp;
            work_min_q <= min_clamp;
            work_sec_q <= sec_clamp;
            tens_min_q <= '0;
            tens_sec_q <= '0;
            ovf_pend_q <= min_over;
            state_q    <= ST_DIV;
          end
        end
        ST_DIV: begin
          if ((work_min_q < 7'd10) && (work_sec_q < 6'd10)) begin
            digits_q <= {tens_min_q, work_min_q[3:0], tens_sec_q, work_sec_q[3:0]};
            ovf_q    <= ovf_pend_q;
            upd_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            if (work_min_q >= 7'd10) begin
              work_min_q <= work_min_q - 7'd10;
              tens_min_q <= tens_min_q + 4'd1;
            end
            if (work_sec_q >= 6'd10) begin
              work_sec_q <= work_sec_q - 6'd10;
              tens_sec_q <= tens_sec_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [REF_W-1:0] ref_q;
  logic [BLK_W-1:0] blk_q;
  logic [1:0]       idx_q;
  logic             phase_q;
  logic [3:0]       an_d, an_q;
  logic [6:0]       seg_d, seg_q;
  logic             dp_d, dp_q;
  logic [3:0]       cur_digit;

  always_comb begin
    an_d      = ~(4'b0001 << idx_q);
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    case (cur_digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    // Colon lives on digit 2's decimal point.
    dp_d = 1'b1;
    if (idx_q == 2'd2) begin
      case (disp_if.status)
        2'b01:   dp_d = ~phase_q;
        2'b10:   dp_d = 1'b0;
        default: dp_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        ref_q <= ref_q + REF_W'(1);
      end
      if (blk_q == BLK_LAST) begin
        blk_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        blk_q <= blk_q + BLK_W'(1);
      end
    end
  end

  assign disp_if.an  = an_q;
  assign disp_if.seg = seg_q;
  assign disp_if.dp  = dp_q;
  assign disp_if.ovf = ovf_q;
  assign disp_if.upd = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_stopwatch_display : directed scoreboard bench for stopwatch_display
// Revision 1.0
// ------------------------------------------------------------------
module tb_stopwatch_display;
  localparam int REFRESH_DIV = 4;
  // Blink period chosen co-prime-ish with the frame so digit-2 slots see both phases.
  localparam int BLINK_DIV   = 6;
  localparam int FRAME       = 4 * REFRESH_DIV;
  localparam logic [6:0] SEG_MAP [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic [15:0] digits;
    logic        ovf;
    logic [31:0] when;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [15:0] shown_digits = '0;
  logic        shown_ovf = 1'b0;

  stopwatch_display_if dif ();

  stopwatch_display #(.REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_if (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference scan/blink timing, sampled on the same edges as the DUT.
  int         m_ref = 0, m_idx = 0, m_blk = 0;
  logic       m_ph = 1'b0;
  logic       exp_dp = 1'b1;
  logic [3:0] exp_an = 4'b1111;
  always @(posedge clk) begin
    if (rst) begin
      m_ref <= 0; m_idx <= 0; m_blk <= 0; m_ph <= 1'b0;
      exp_dp <= 1'b1; exp_an <= 4'b1111;
    end else begin
      exp_an <= AN_SEQ[m_idx];
      exp_dp <= (m_idx != 2) ? 1'b1 :
                (dif.status == 2'b01) ? ~m_ph :
                (dif.status == 2'b10) ? 1'b0 : 1'b1;
      m_ref <= (m_ref == REFRESH_DIV - 1) ? 0 : m_ref + 1;
      m_idx <= (m_ref == REFRESH_DIV - 1) ? (m_idx + 1) % 4 : m_idx;
      m_blk <= (m_blk == BLINK_DIV - 1) ? 0 : m_blk + 1;
      m_ph  <= (m_blk == BLINK_DIV - 1) ? ~m_ph : m_ph;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t make_exp(input int m, input int s, input int load_edge);
    int mc, sc, tm, ts;
    exp_t e;
    mc = (m > 99) ? 99 : m;
    sc = (s > 59) ? 59 : s;
    tm = mc / 10;
    ts = sc / 10;
    e.digits = {4'(tm), 4'(mc % 10), 4'(ts), 4'(sc % 10)};
    e.ovf    = (m > 99);
    e.when   = 32'(load_edge + 1 + ((tm > ts) ? tm : ts));
    return e;
  endfunction

  task automatic apply(input int m, input int s);
    dif.minutes = 8'(m);
    dif.seconds = 6'(s);
  endtask

  task automatic apply_push(input int m, input int s);
    apply(m, s);
    sb_q.push_back(make_exp(m, s, cyc + 1));
  endtask

  task automatic wait_upd();
    int   budget;
    exp_t e;
    budget = 40;
    while (sb_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (dif.upd === 1'b1) begin
        e = sb_q.pop_front();
        chk("upd_edge", 32'(cyc), e.when);
        chk("ovf_commit", 32'(dif.ovf), 32'(e.ovf));
        shown_digits = e.digits;
        shown_ovf    = e.ovf;
      end
    end
    if (sb_q.size() > 0) begin
      chk("upd_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_frame();
    int idx;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("an", 32'(dif.an), 32'(exp_an));
      idx = -1;
      for (int d = 0; d < 4; d++) if (AN_SEQ[d] == dif.an) idx = d;
      if (idx >= 0) chk("seg", 32'(dif.seg), 32'(SEG_MAP[shown_digits[idx*4 +: 4]]));
      chk("dp", 32'(dif.dp), 32'(exp_dp));
      chk("upd_quiet", 32'(dif.upd), 32'd0);
      chk("ovf_hold", 32'(dif.ovf), 32'(shown_ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    int   seen0, seen1;
    dif.minutes = '0;
    dif.seconds = '0;
    dif.status  = 2'b00;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_an", 32'(dif.an), 32'hF);
    chk("rst_seg", 32'(dif.seg), 32'h7F);
    chk("rst_dp", 32'(dif.dp), 32'd1);
    chk("rst_ovf", 32'(dif.ovf), 32'd0);
    chk("rst_upd", 32'(dif.upd), 32'd0);

    rst = 1'b0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      tick();
      chk("scan_an", 32'(dif.an), 32'(AN_SEQ[(j / REFRESH_DIV) % 4]));
      chk("scan_seg", 32'(dif.seg), 32'(7'b1000000));
      chk("scan_upd", 32'(dif.upd), 32'd0);
    end

    dif.status = 2'b01;
    seen0 = 0;
    seen1 = 0;
    for (int j = 0; j < 3 * FRAME; j++) begin
      tick();
      chk("dp_run", 32'(dif.dp), 32'(exp_dp));
      if (dif.an == 4'b1011) begin
        if (dif.dp === 1'b0) seen0++;
        if (dif.dp === 1'b1) seen1++;
      end
    end
    chk("dp_blinks", 32'((seen0 > 0) && (seen1 > 0)), 32'd1);
    dif.status = 2'b10;
    for (int j = 0; j < FRAME; j++) begin
      tick();
      chk("dp_pause", 32'(dif.dp), 32'(dif.an == 4'b1011 ? 1'b0 : 1'b1));
    end
    dif.status = 2'b11;
    for (int j = 0; j < FRAME; j++) begin
      tick();
      chk("dp_st11", 32'(dif.dp), 32'd1);
    end
    dif.status = 2'b00;

    apply_push(12, 34);
    wait_upd();
    check_frame();

    apply_push(150, 63);
    wait_upd();
    check_frame();
    apply_push(5, 63);
    wait_upd();
    check_frame();

    apply(99, 59);
    e1 = make_exp(99, 59, cyc + 1);
    sb_q.push_back(e1);
    tick();
    tick();
    apply(0, 7);
    sb_q.push_back(make_exp(0, 7, int'(e1.when) + 1));
    dif.status = 2'b10;
    wait_upd();
    check_frame();
    dif.status = 2'b00;

    apply(45, 50);
    tick();
    chk("mid_upd0", 32'(dif.upd), 32'd0);
    tick();
    chk("mid_upd1", 32'(dif.upd), 32'd0);
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("mid_rst_an", 32'(dif.an), 32'hF);
      chk("mid_rst_seg", 32'(dif.seg), 32'h7F);
      chk("mid_rst_dp", 32'(dif.dp), 32'd1);
      chk("mid_rst_upd", 32'(dif.upd), 32'd0);
      chk("mid_rst_ovf", 32'(dif.ovf), 32'd0);
    end
    rst = 1'b0;
    shown_digits = '0;
    shown_ovf    = 1'b0;
    sb_q.push_back(make_exp(45, 50, cyc + 1));
    tick();
    chk("rel_an", 32'(dif.an), 32'(4'b1110));
    chk("rel_seg", 32'(dif.seg), 32'(7'b1000000));
    chk("rel_upd", 32'(dif.upd), 32'd0);
    wait_upd();
    check_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
